// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Operand snoop helper is reused by insert-time capture and in-station wakeup.
package alu_rs_pkg;

  localparam int RS_SIZE = 16;
  localparam int ROB_W   = 4;
  localparam int RS_IW   = $clog2(RS_SIZE);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [ROB_W-1:0] rob_pos;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    logic [31:0]      val1;
    logic [31:0]      val2;
    logic [31:0]      imm;
    logic [31:0]      pc;
  } op_t;

  typedef struct packed {
    logic             busy;
    logic             has_dep1;
    logic             has_dep2;
    logic [ROB_W-1:0] dep1;
    logic [ROB_W-1:0] dep2;
    op_t              op;
  } rs_entry_t;

  typedef struct packed {
    logic        has_dep;
    logic [31:0] val;
  } operand_t;

  // LSB is applied after ALU; both can only match the same tag if the ROB is broken.
  function automatic operand_t snoop(
    input operand_t         cur,
    input logic [ROB_W-1:0] dep,
    input logic             a_vld,
    input logic [ROB_W-1:0] a_tag,
    input logic [31:0]      a_val,
    input logic             l_vld,
    input logic [ROB_W-1:0] l_tag,
    input logic [31:0]      l_val
  );
    operand_t r;
    r = cur;
    if (cur.has_dep && a_vld && dep == a_tag) begin
      r.has_dep = 1'b0;
      r.val     = a_val;
    end
    if (cur.has_dep && l_vld && dep == l_tag) begin
      r.has_dep = 1'b0;
      r.val     = l_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_find_first.sv
// Lowest-index priority encoder: returns the index of the first set request bit and a found flag.
module rs_find_first #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from ALU/LSB broadcasts,
// issues the lowest-index ready entry to the ALU, one per cycle, with registered outputs.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             issue_en,
  input  logic [ROB_W-1:0] issue_rob_pos,
  input  logic [6:0]       issue_opcode,
  input  logic [2:0]       issue_funct3,
  input  logic             issue_funct7,
  input  logic [31:0]      issue_val1,
  input  logic [31:0]      issue_val2,
  input  logic             issue_has_dep1,
  input  logic             issue_has_dep2,
  input  logic [ROB_W-1:0] issue_dep1,
  input  logic [ROB_W-1:0] issue_dep2,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  output logic             rs_full,
  output logic             alu_en,
  output logic [ROB_W-1:0] alu_rob_pos,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_funct3,
  output logic             alu_funct7,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  input  logic             alu_result,
  input  logic [ROB_W-1:0] alu_result_rob_pos,
  input  logic [31:0]      alu_result_val,
  input  logic             lsb_result,
  input  logic [ROB_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]      lsb_result_val
);

  rs_entry_t ents_q [RS_SIZE];
  rs_entry_t ents_d [RS_SIZE];
  op_t       out_q, out_d;
  logic      alu_en_q, alu_en_d;

  logic [RS_SIZE-1:0] busy_vec, ready_vec;
  logic [RS_IW-1:0]   free_idx, sel_idx;
  logic               free_found, sel_found;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ents_q[i].busy;
      ready_vec[i] = ents_q[i].busy & ~ents_q[i].has_dep1 & ~ents_q[i].has_dep2;
    end
  end

  rs_find_first #(.N(RS_SIZE)) u_free (
    .req_i   (~busy_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_find_first #(.N(RS_SIZE)) u_ready (
    .req_i   (ready_vec),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  assign rs_full = &busy_vec;

  always_comb begin
    operand_t o1, o2;
    rs_entry_t ne;
    ents_d   = ents_q;
    out_d    = out_q;
    alu_en_d = 1'b0;
    o1       = '0;
    o2       = '0;
    ne       = '0;

    // Wakeup: both buses apply to every waiting operand.
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ents_q[i].busy) begin
        o1 = snoop('{has_dep: ents_q[i].has_dep1, val: ents_q[i].op.val1}, ents_q[i].dep1,
                   alu_result, alu_result_rob_pos, alu_result_val,
                   lsb_result, lsb_result_rob_pos, lsb_result_val);
        o2 = snoop('{has_dep: ents_q[i].has_dep2, val: ents_q[i].op.val2}, ents_q[i].dep2,
                   alu_result, alu_result_rob_pos, alu_result_val,
                   lsb_result, lsb_result_rob_pos, lsb_result_val);
        ents_d[i].has_dep1 = o1.has_dep;
        ents_d[i].op.val1  = o1.val;
        ents_d[i].has_dep2 = o2.has_dep;
        ents_d[i].op.val2  = o2.val;
      end
    end

    // Select works on registered state, so a just-woken operand issues one cycle later.
    if (sel_found) begin
      out_d                 = ents_q[sel_idx].op;
      alu_en_d              = 1'b1;
      ents_d[sel_idx].busy  = 1'b0;
    end

    // Insert into a free slot; never collides with the selected (busy) slot.
    if (issue_en && free_found) begin
      o1 = snoop('{has_dep: issue_has_dep1, val: issue_val1}, issue_dep1,
                 alu_result, alu_result_rob_pos, alu_result_val,
                 lsb_result, lsb_result_rob_pos, lsb_result_val);
      o2 = snoop('{has_dep: issue_has_dep2, val: issue_val2}, issue_dep2,
                 alu_result, alu_result_rob_pos, alu_result_val,
                 lsb_result, lsb_result_rob_pos, lsb_result_val);
      ne.busy       = 1'b1;
      ne.has_dep1   = o1.has_dep;
      ne.has_dep2   = o2.has_dep;
      ne.dep1       = issue_dep1;
      ne.dep2       = issue_dep2;
      ne.op.rob_pos = issue_rob_pos;
      ne.op.opcode  = issue_opcode;
      ne.op.funct3  = issue_funct3;
      ne.op.funct7  = issue_funct7;
      ne.op.val1    = o1.val;
      ne.op.val2    = o2.val;
      ne.op.imm     = issue_imm;
      ne.op.pc      = issue_pc;
      ents_d[free_idx] = ne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      for (int i = 0; i < RS_SIZE; i++) ents_q[i] <= '0;
      out_q    <= '0;
      alu_en_q <= 1'b0;
    end else if (rdy) begin
      ents_q   <= ents_d;
      out_q    <= out_d;
      alu_en_q <= alu_en_d;
    end
  end

  assign alu_en      = alu_en_q;
  assign alu_rob_pos = out_q.rob_pos;
  assign alu_opcode  = out_q.opcode;
  assign alu_funct3  = out_q.funct3;
  assign alu_funct7  = out_q.funct7;
  assign alu_val1    = out_q.val1;
  assign alu_val2    = out_q.val2;
  assign alu_imm     = out_q.imm;
  assign alu_pc      = out_q.pc;

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: reset, issue latency, wakeup, insert snoop, full drain, rollback, freeze.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic             clk = 1'b0;
  logic             rst, rdy, rollback, issue_en;
  logic [ROB_W-1:0] issue_rob_pos, issue_dep1, issue_dep2;
  logic [6:0]       issue_opcode;
  logic [2:0]       issue_funct3;
  logic             issue_funct7, issue_has_dep1, issue_has_dep2;
  logic [31:0]      issue_val1, issue_val2, issue_imm, issue_pc;
  logic             rs_full, alu_en;
  logic [ROB_W-1:0] alu_rob_pos;
  logic [6:0]       alu_opcode;
  logic [2:0]       alu_funct3;
  logic             alu_funct7;
  logic [31:0]      alu_val1, alu_val2, alu_imm, alu_pc;
  logic             alu_result, lsb_result;
  logic [ROB_W-1:0] alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0]      alu_result_val, lsb_result_val;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .issue_en(issue_en),
    .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_has_dep1(issue_has_dep1), .issue_has_dep2(issue_has_dep2),
    .issue_dep1(issue_dep1), .issue_dep2(issue_dep2), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .rs_full(rs_full), .alu_en(alu_en), .alu_rob_pos(alu_rob_pos), .alu_opcode(alu_opcode),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [3:0] rob, input logic [6:0] opc, input logic [31:0] v1,
                     input logic [31:0] v2, input logic hd1, input logic [3:0] d1,
                     input logic hd2, input logic [3:0] d2, input logic [31:0] imm);
    issue_en = 1'b1; issue_rob_pos = rob; issue_opcode = opc; issue_funct3 = 3'd0;
    issue_funct7 = 1'b0; issue_val1 = v1; issue_val2 = v2; issue_has_dep1 = hd1;
    issue_dep1 = d1; issue_has_dep2 = hd2; issue_dep2 = d2; issue_imm = imm;
    issue_pc = 32'h1000 + {26'd0, rob, 2'b00};
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue_en = 1'b0;
    issue_rob_pos = '0; issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 1'b0;
    issue_val1 = '0; issue_val2 = '0; issue_has_dep1 = 1'b0; issue_has_dep2 = 1'b0;
    issue_dep1 = '0; issue_dep2 = '0; issue_imm = '0; issue_pc = '0;
    alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;

    // 1: reset
    step(); step();
    rst = 1'b0;
    check("rst_alu_en", {31'd0, alu_en}, 32'd0);
    check("rst_full", {31'd0, rs_full}, 32'd0);
    check("rst_rob", {28'd0, alu_rob_pos}, 32'd0);
    check("rst_val1", alu_val1, 32'd0);
    check("rst_val2", alu_val2, 32'd0);
    check("rst_imm", alu_imm, 32'd0);
    check("rst_pc", alu_pc, 32'd0);
    check("rst_opc", {25'd0, alu_opcode}, 32'd0);

    // 2: ready ADDI issues one cycle after insert, as a single pulse
    put(4'd2, OPC_OP_IMM, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd3);
    step();
    issue_en = 1'b0;
    check("addi_not_yet", {31'd0, alu_en}, 32'd0);
    step();
    check("addi_en", {31'd0, alu_en}, 32'd1);
    check("addi_rob", {28'd0, alu_rob_pos}, 32'd2);
    check("addi_val1", alu_val1, 32'd5);
    check("addi_imm", alu_imm, 32'd3);
    check("addi_opc", {25'd0, alu_opcode}, {25'd0, OPC_OP_IMM});
    check("addi_pc", alu_pc, 32'h1008);
    step();
    check("addi_pulse_end", {31'd0, alu_en}, 32'd0);

    // 3: ADD waits on tag 1, wakes from ALU broadcast
    put(4'd3, OPC_OP, 32'd0, 32'd2, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0);
    step();
    issue_en = 1'b0;
    step();
    check("add_wait", {31'd0, alu_en}, 32'd0);
    alu_result = 1'b1; alu_result_rob_pos = 4'd1; alu_result_val = 32'h10;
    step();
    alu_result = 1'b0;
    check("add_wake_lat", {31'd0, alu_en}, 32'd0);
    step();
    check("add_en", {31'd0, alu_en}, 32'd1);
    check("add_rob", {28'd0, alu_rob_pos}, 32'd3);
    check("add_val1", alu_val1, 32'h10);
    check("add_val2", alu_val2, 32'd2);
    step();

    // 4: operand captured from LSB broadcast in the insert cycle
    put(4'd6, OPC_OP, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'd0);
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'd7;
    step();
    issue_en = 1'b0; lsb_result = 1'b0;
    check("snoop_not_yet", {31'd0, alu_en}, 32'd0);
    step();
    check("snoop_en", {31'd0, alu_en}, 32'd1);
    check("snoop_rob", {28'd0, alu_rob_pos}, 32'd6);
    check("snoop_val2", alu_val2, 32'd7);
    step();

    // 5: fill all entries waiting on tag 5, then drain in index order
    for (int i = 0; i < RS_SIZE; i++) begin
      put(4'(i), OPC_OP, 32'd0, 32'(i), 1'b1, 4'd5, 1'b0, 4'd0, 32'd0);
      step();
    end
    issue_en = 1'b0;
    check("fill_full", {31'd0, rs_full}, 32'd1);
    check("fill_no_issue", {31'd0, alu_en}, 32'd0);
    alu_result = 1'b1; alu_result_rob_pos = 4'd5; alu_result_val = 32'h55;
    step();
    alu_result = 1'b0;
    check("fill_full_after_wake", {31'd0, rs_full}, 32'd1);
    for (int i = 0; i < RS_SIZE; i++) begin
      step();
      check("drain_en", {31'd0, alu_en}, 32'd1);
      check("drain_rob", {28'd0, alu_rob_pos}, 32'(i));
      check("drain_val2", alu_val2, 32'(i));
      if (i == 0) check("drain_not_full", {31'd0, rs_full}, 32'd0);
    end
    check("drain_val1", alu_val1, 32'h55);
    step();
    check("drain_done", {31'd0, alu_en}, 32'd0);

    // 6a: rollback flushes waiting entries and a ready entry about to issue
    for (int i = 0; i < 5; i++) begin
      put(4'(8 + i), OPC_BRANCH, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 32'd0);
      step();
    end
    put(4'd13, OPC_OP_IMM, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1);
    step();
    put(4'd14, OPC_OP_IMM, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1);
    rollback = 1'b1;
    step();
    rollback = 1'b0; issue_en = 1'b0;
    check("rb_alu_en", {31'd0, alu_en}, 32'd0);
    check("rb_full", {31'd0, rs_full}, 32'd0);
    check("rb_rob", {28'd0, alu_rob_pos}, 32'd0);
    alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h99;
    step();
    alu_result = 1'b0;
    check("rb_after_bcast0", {31'd0, alu_en}, 32'd0);
    step();
    check("rb_after_bcast1", {31'd0, alu_en}, 32'd0);
    step();
    check("rb_after_bcast2", {31'd0, alu_en}, 32'd0);

    // 6b: rdy low freezes outputs and ignores broadcasts
    put(4'd13, OPC_JALR, 32'd3, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd4);
    step();
    put(4'd14, OPC_OP, 32'd0, 32'd8, 1'b1, 4'd10, 1'b0, 4'd0, 32'd0);
    step();
    issue_en = 1'b0;
    check("frz_en0", {31'd0, alu_en}, 32'd1);
    check("frz_rob0", {28'd0, alu_rob_pos}, 32'd13);
    rdy = 1'b0;
    alu_result = 1'b1; alu_result_rob_pos = 4'd10; alu_result_val = 32'h77;
    step(); step();
    check("frz_en_hold", {31'd0, alu_en}, 32'd1);
    check("frz_rob_hold", {28'd0, alu_rob_pos}, 32'd13);
    check("frz_val1_hold", alu_val1, 32'd3);
    rdy = 1'b1; alu_result = 1'b0;
    step();
    check("frz_no_wake0", {31'd0, alu_en}, 32'd0);
    step();
    check("frz_no_wake1", {31'd0, alu_en}, 32'd0);
    alu_result = 1'b1; alu_result_rob_pos = 4'd10; alu_result_val = 32'h78;
    step();
    alu_result = 1'b0;
    step();
    check("frz_late_en", {31'd0, alu_en}, 32'd1);
    check("frz_late_rob", {28'd0, alu_rob_pos}, 32'd14);
    check("frz_late_val1", alu_val1, 32'h78);
    step();
    check("frz_late_end", {31'd0, alu_en}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
